tmem_xbar: RTL

Parametrised texture-memory crossbar connecting `NUM_CORES` shader-core read ports to `NUM_BANKS` interleaved texture-memory banks. Each bank has its own round-robin read arbiter. A host write port targets banks through the same linear address space. It replaces the fixed 4x4 crossbar in the THEIA top level and sits between the core array and the texture RAM banks. Bank storage is instantiated internally.

---
 rtl/theia_xbar_pkg.sv | 21 ++
 rtl/ram_single_read_port.sv | 28 ++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/tmem_xbar.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/theia_xbar_pkg.sv
// Shared helpers for the texture-memory crossbar: a constant-evaluable
// ceiling-log2 and the derived widths for the default 4x4 configuration.
package theia_xbar_pkg;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(50000) = 16.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int BANK_BITS  = clog2(4);
    localparam int CORE_BITS  = clog2(4);
    localparam int DEPTH_BITS = clog2(50000);

endpackage

// File: rtl/ram_single_read_port.sv
// One texture bank: synchronous write, registered synchronous read on a
// shared address. Contents are never cleared.
module RAM_SINGLE_READ_PORT #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 50000
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write and read share the address; the crossbar never asserts both.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one texture bank. Search starts one past the
// last winner and wraps; the pointer only moves when a grant is issued.
module rr_arbiter
    import theia_xbar_pkg::*;
#(
    parameter int NUM_CORES = 4,
    localparam int coreBits = clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 hold,
    input  logic                 enable,
    input  logic [NUM_CORES-1:0] mask,
    output logic [NUM_CORES-1:0] grant,
    output logic [coreBits-1:0]  index
);

    logic [coreBits-1:0]  ptr;
    logic [NUM_CORES-1:0] eligible;
    logic [coreBits-1:0]  cand;
    logic                 found;
    int                   sum;

    // Pick the first eligible core after the pointer, unless held by a host write.
    always_comb begin
        eligible = req & ~mask;
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = '0;
        sum      = 0;
        if (enable && !hold) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                sum = int'(ptr) + k;
                if (sum >= NUM_CORES) begin
                    sum = sum - NUM_CORES;
                end
                cand = coreBits'(sum);
                if (!found && eligible[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    index       = cand;
                end
            end
        end
    end

    // Last-grant pointer: reset so core 0 is searched first, then follow winners.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            ptr <= coreBits'(NUM_CORES - 1);
        end else if (found) begin
            ptr <= index;
        end
    end

endmodule

// File: rtl/tmem_xbar.sv
// Texture-memory crossbar: NUM_CORES read ports onto NUM_BANKS low-order
// interleaved banks, one round-robin arbiter per bank, host write port
// with priority over reads on the bank it targets.
//
// Handshake: a core raises REQ_I and holds it (address stable) until it
// sees GNT_O high for exactly one cycle; DAT_O for that core is valid in
// that same cycle. The core drops REQ_I during the grant cycle; a core
// whose GNT_O is high is ignored by arbitration, so it is never served twice.
module tmem_xbar
    import theia_xbar_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BANK_DEPTH = 50000
) (
    input  logic                             CLK_I,
    input  logic                             RST_I,
    input  logic [NUM_CORES-1:0]             REQ_I,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  ADR_I,
    output logic [NUM_CORES-1:0]             GNT_O,
    output logic [NUM_CORES*DATA_WIDTH-1:0]  DAT_O,
    input  logic                             TMWE_I,
    input  logic [ADDR_WIDTH-1:0]            TMADR_I,
    input  logic [DATA_WIDTH-1:0]            TMDAT_I,
    output logic [NUM_BANKS-1:0]             CONFLICT_O
);

    localparam int bankBits  = clog2(NUM_BANKS);
    localparam int coreBits  = clog2(NUM_CORES);
    localparam int depthBits = clog2(BANK_DEPTH);
    localparam int bankSelW  = (bankBits > 0) ? bankBits : 1;

    function automatic logic [bankSelW-1:0] bankOf(input logic [ADDR_WIDTH-1:0] adr);
        return (bankBits == 0) ? '0 : bankSelW'(adr);
    endfunction

    function automatic logic [depthBits-1:0] physOf(input logic [ADDR_WIDTH-1:0] adr);
        return depthBits'(adr >> bankBits);
    endfunction

    logic [bankSelW-1:0]   coreBank  [NUM_CORES];
    logic [depthBits-1:0]  corePhys  [NUM_CORES];
    logic [bankSelW-1:0]   bankSelQ  [NUM_CORES];
    logic [NUM_CORES-1:0]  gntByBank [NUM_BANKS];
    logic [DATA_WIDTH-1:0] ramQ      [NUM_BANKS];
    logic [NUM_CORES-1:0]  gntD;
    logic [NUM_CORES-1:0]  gntQ;
    logic [NUM_BANKS-1:0]  conflictD;
    logic [NUM_BANKS-1:0]  conflictQ;
    logic [bankSelW-1:0]   wrBank;
    logic [depthBits-1:0]  wrPhys;

    assign wrBank = bankOf(TMADR_I);
    assign wrPhys = physOf(TMADR_I);

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        assign coreBank[c] = bankOf(ADR_I[c*ADDR_WIDTH +: ADDR_WIDTH]);
        assign corePhys[c] = physOf(ADR_I[c*ADDR_WIDTH +: ADDR_WIDTH]);
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_CORES-1:0] routedReq;
        logic [NUM_CORES-1:0] maskedReq;
        logic [coreBits-1:0]  winIdx;
        logic [depthBits-1:0] ramAdr;
        logic                 hold;

        // Present each core's request only to the bank its address maps to.
        always_comb begin
            routedReq = '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                routedReq[c] = REQ_I[c] && (coreBank[c] == bankSelW'(b));
            end
        end

        assign hold      = TMWE_I && (wrBank == bankSelW'(b));
        assign maskedReq = routedReq & ~gntQ;
        assign ramAdr    = hold ? wrPhys : corePhys[winIdx];
        // Contention: two or more live requesters, or any requester blocked by the host.
        assign conflictD[b] = hold ? (maskedReq != '0)
                                   : ((maskedReq & (maskedReq - NUM_CORES'(1))) != '0);

        rr_arbiter #(
            .NUM_CORES (NUM_CORES)
        ) u_arb (
            .clk    (CLK_I),
            .rstN   (RST_I),
            .req    (routedReq),
            .hold   (hold),
            .enable (1'b1),
            .mask   (gntQ),
            .grant  (gntByBank[b]),
            .index  (winIdx)
        );

        RAM_SINGLE_READ_PORT #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (depthBits),
            .DEPTH      (BANK_DEPTH)
        ) u_ram (
            .clk   (CLK_I),
            .we    (hold),
            .re    (|gntByBank[b]),
            .addr  (ramAdr),
            .wdata (TMDAT_I),
            .rdata (ramQ[b])
        );
    end

    // A core can only be granted by the bank it targets, so OR the bank grants.
    always_comb begin
        gntD = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gntD = gntD | gntByBank[b];
        end
    end

    // Register grants and conflicts; remember which bank feeds each granted core.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            gntQ      <= '0;
            conflictQ <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                bankSelQ[c] <= '0;
            end
        end else begin
            gntQ      <= gntD;
            conflictQ <= conflictD;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (gntD[c]) begin
                    bankSelQ[c] <= coreBank[c];
                end
            end
        end
    end

    // Route bank read data to each core during its grant cycle, zero otherwise.
    always_comb begin
        DAT_O = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (gntQ[c]) begin
                DAT_O[c*DATA_WIDTH +: DATA_WIDTH] = ramQ[bankSelQ[c]];
            end
        end
    end

    assign GNT_O      = gntQ;
    assign CONFLICT_O = conflictQ;

endmodule
